alu32_reg: RTL and testbench

- 32-bit registered ALU for the processor execute stage.
- Computes arithmetic, bitwise, move-high and compare results selected by a 6-bit opcode.
- Result is captured on the rising clock edge; one cycle latency.
- Comparison ops return 0 or 1 for the branch/compare datapath.

---
 rtl/alu32_reg.sv | 126 ++++++++++++
 tb/tb_alu32_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu32_reg.sv
// alu32_reg: 32-bit execute-stage ALU with a registered result.
// The result is computed combinationally from opsel/A/B.
// It is captured on the rising clock edge, giving exactly one cycle of latency.
// Compare operations are signed and return 0 or 1.
module alu32_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opsel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] out
);

   // Opcode encodings
   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_SUB  = 6'h01;
   localparam logic [5:0] OP_AND  = 6'h04;
   localparam logic [5:0] OP_OR   = 6'h05;
   localparam logic [5:0] OP_XOR  = 6'h06;
   localparam logic [5:0] OP_MVHI = 6'h0B;
   localparam logic [5:0] OP_NAND = 6'h0C;
   localparam logic [5:0] OP_NOR  = 6'h0D;
   localparam logic [5:0] OP_XNOR = 6'h0E;
   localparam logic [5:0] OP_F    = 6'h10;
   localparam logic [5:0] OP_EQ   = 6'h11;
   localparam logic [5:0] OP_LT   = 6'h12;
   localparam logic [5:0] OP_LTE  = 6'h13;
   localparam logic [5:0] OP_EQZ  = 6'h15;
   localparam logic [5:0] OP_LTZ  = 6'h16;
   localparam logic [5:0] OP_LTEZ = 6'h17;
   localparam logic [5:0] OP_T    = 6'h18;
   localparam logic [5:0] OP_NE   = 6'h19;
   localparam logic [5:0] OP_GTE  = 6'h1A;
   localparam logic [5:0] OP_GT   = 6'h1B;
   localparam logic [5:0] OP_NEZ  = 6'h1D;
   localparam logic [5:0] OP_GTEZ = 6'h1E;
   localparam logic [5:0] OP_GTZ  = 6'h1F;

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] out_next;

   logic [WIDTH-1:0] sum_res;
   logic [WIDTH-1:0] diff_res;
   logic [WIDTH-1:0] and_bits;
   logic [WIDTH-1:0] or_bits;
   logic [WIDTH-1:0] xor_bits;
   logic [WIDTH-1:0] mvhi_res;

   logic a_eq_b;
   logic a_lt_b;
   logic a_zero;
   logic a_neg;

   // Modulo-2^WIDTH arithmetic; carry-out and overflow are simply dropped
   assign sum_res  = A + B;
   assign diff_res = A - B;

   // Per-bit logic slices; the inverted forms are taken from these in the mux
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign and_bits[gi] = A[gi] & B[gi];
         assign or_bits[gi]  = A[gi] | B[gi];
         assign xor_bits[gi] = A[gi] ^ B[gi];
      end
   endgenerate

   // Low half of B moved to the high half, low half cleared
   assign mvhi_res = {B[15:0], {(WIDTH-16){1'b0}}};

   // Shared signed relations; every compare opcode is derived from these four
   assign a_eq_b = (A == B);
   assign a_lt_b = ($signed(A) < $signed(B));
   assign a_zero = (A == '0);
   assign a_neg  = A[WIDTH-1];

   // Zero-extend a single truth bit into a full-width compare result
   function automatic logic [WIDTH-1:0] flag(input logic b);
      return {{(WIDTH-1){1'b0}}, b};
   endfunction

   // Result select; unlisted opcodes yield zero
   always_comb begin
      out_next = '0;
      case (opsel)
         OP_ADD:  out_next = sum_res;
         OP_SUB:  out_next = diff_res;
         OP_AND:  out_next = and_bits;
         OP_OR:   out_next = or_bits;
         OP_XOR:  out_next = xor_bits;
         OP_MVHI: out_next = mvhi_res;
         OP_NAND: out_next = ~and_bits;
         OP_NOR:  out_next = ~or_bits;
         OP_XNOR: out_next = ~xor_bits;
         OP_F:    out_next = flag(1'b0);
         OP_EQ:   out_next = flag(a_eq_b);
         OP_LT:   out_next = flag(a_lt_b);
         OP_LTE:  out_next = flag(a_lt_b | a_eq_b);
         OP_T:    out_next = flag(1'b1);
         OP_NE:   out_next = flag(~a_eq_b);
         OP_GTE:  out_next = flag(~a_lt_b);
         OP_GT:   out_next = flag(~(a_lt_b | a_eq_b));
         OP_EQZ:  out_next = flag(a_zero);
         OP_LTZ:  out_next = flag(a_neg);
         OP_LTEZ: out_next = flag(a_neg | a_zero);
         OP_NEZ:  out_next = flag(~a_zero);
         OP_GTEZ: out_next = flag(~a_neg);
         OP_GTZ:  out_next = flag(~(a_neg | a_zero));
         default: out_next = '0;
      endcase
   end

   // Result register; reset clears it immediately and discards any pending result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
      end else begin
         out_reg <= out_next;
      end
   end

   assign out = out_reg;

endmodule

// File: tb/tb_alu32_reg.sv
// tb_alu32_reg: table-driven directed checks of alu32_reg.
// It also runs hand-written reset and latency sequences.
module tb_alu32_reg;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opsel;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] out;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   alu32_reg #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .opsel (opsel),
      .A     (A),
      .B     (B),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      opsel = 6'h00;
      A     = 32'd7;
      B     = 32'd9;

      // Directed vectors
      add(6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "ADD -1+-1");
      add(6'h00, 32'd5,        32'hFFFFFFFF, 32'd4,        "ADD 5+-1");
      add(6'h01, 32'd0,        32'd5,        32'hFFFFFFFB, "SUB 0-5");
      add(6'h01, 32'd5,        32'hFFFFFFFF, 32'd6,        "SUB 5--1");
      add(6'h00, 32'h7FFFFFFF, 32'd1,        32'h80000000, "ADD wrap");
      add(6'h01, 32'h80000000, 32'd1,        32'h7FFFFFFF, "SUB wrap");
      add(6'h04, 32'd5,        32'hFFFFFFFF, 32'd5,        "AND");
      add(6'h05, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, "OR");
      add(6'h06, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFA, "XOR");
      add(6'h0C, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFA, "NAND");
      add(6'h0D, 32'd5,        32'hFFFFFFFF, 32'h00000000, "NOR");
      add(6'h0E, 32'd5,        32'hFFFFFFFF, 32'd5,        "XNOR");
      add(6'h04, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h00F00000, "AND mix");
      add(6'h0B, 32'hFFFFFFFF, 32'h00010005, 32'h00050000, "MVHI");
      add(6'h12, 32'hFFFFFFFF, 32'd5,        32'd1,        "LT -1,5");
      add(6'h13, 32'hFFFFFFFF, 32'd5,        32'd1,        "LTE -1,5");
      add(6'h1B, 32'hFFFFFFFF, 32'd5,        32'd0,        "GT -1,5");
      add(6'h1A, 32'hFFFFFFFF, 32'd5,        32'd0,        "GTE -1,5");
      add(6'h11, 32'hFFFFFFFF, 32'd5,        32'd0,        "EQ -1,5");
      add(6'h19, 32'hFFFFFFFF, 32'd5,        32'd1,        "NE -1,5");
      add(6'h1B, 32'd5,        32'hFFFFFFFF, 32'd1,        "GT 5,-1");
      add(6'h13, 32'd5,        32'd5,        32'd1,        "LTE 5,5");
      add(6'h11, 32'd5,        32'd5,        32'd1,        "EQ 5,5");
      add(6'h12, 32'd5,        32'd5,        32'd0,        "LT 5,5");
      add(6'h1A, 32'd5,        32'd5,        32'd1,        "GTE 5,5");
      add(6'h19, 32'd5,        32'd5,        32'd0,        "NE 5,5");
      add(6'h12, 32'h80000000, 32'h7FFFFFFF, 32'd1,        "LT min,max");
      add(6'h10, 32'd5,        32'd5,        32'd0,        "F");
      add(6'h18, 32'd0,        32'hFFFFFFFF, 32'd1,        "T");
      add(6'h15, 32'd0,        32'h12345678, 32'd1,        "EQZ 0");
      add(6'h17, 32'd0,        32'hFFFFFFFF, 32'd1,        "LTEZ 0");
      add(6'h1E, 32'd0,        32'd0,        32'd1,        "GTEZ 0");
      add(6'h1F, 32'd0,        32'hFFFFFFFF, 32'd0,        "GTZ 0");
      add(6'h16, 32'hFFFFFFFF, 32'd0,        32'd1,        "LTZ -1");
      add(6'h1D, 32'hFFFFFFFF, 32'd0,        32'd1,        "NEZ -1");
      add(6'h1E, 32'hFFFFFFFF, 32'd0,        32'd0,        "GTEZ -1");
      add(6'h1F, 32'd1,        32'hFFFFFFFF, 32'd1,        "GTZ 1");
      add(6'h16, 32'd1,        32'hFFFFFFFF, 32'd0,        "LTZ 1");
      add(6'h15, 32'h80000000, 32'd0,        32'd0,        "EQZ min");
      add(6'h00, 32'h11111111, 32'h22222222, 32'h33333333, "ADD pre-ill");
      add(6'h3F, 32'd5,        32'd5,        32'd0,        "ILL 3F");
      add(6'h18, 32'd1,        32'd2,        32'd1,        "T pre-ill");
      add(6'h02, 32'd5,        32'd5,        32'd0,        "ILL 02");
      add(6'h05, 32'd5,        32'd6,        32'd7,        "OR pre-ill");
      add(6'h14, 32'd0,        32'd0,        32'd0,        "ILL 14");
      add(6'h18, 32'd1,        32'd2,        32'd1,        "T pre-ill2");
      add(6'h1C, 32'd1,        32'd0,        32'd0,        "ILL 1C");

      // Reset state while held in reset, across clock edges
      repeat (2) @(posedge clk);
      #1 check("reset state", out, 32'h0);

      // Release on a falling edge so it is seen at the next rising edge
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors: drive on the falling edge, sample 1 after the rising edge
      foreach (vecs[i]) begin
         @(negedge clk);
         opsel = vecs[i].op;
         A     = vecs[i].a;
         B     = vecs[i].b;
         @(posedge clk);
         #1 check(vecs[i].name, out, vecs[i].exp);
      end

      // Operands toggling between edges: out holds, then takes only the last value
      @(negedge clk);
      opsel = 6'h00; A = 32'd100; B = 32'd23;
      @(posedge clk);
      #1 check("glitch setup", out, 32'd123);
      A = 32'd1; B = 32'd1;
      #1 check("glitch hold1", out, 32'd123);
      opsel = 6'h06; A = 32'hFFFF0000;
      #1 check("glitch hold2", out, 32'd123);
      @(posedge clk);
      #1 check("glitch final", out, 32'hFFFF0001);

      // Asynchronous reset mid-cycle with a pending result
      @(negedge clk);
      opsel = 6'h00; A = 32'd40; B = 32'd2;
      #2 rst_n = 1'b0;
      #1 check("async reset", out, 32'h0);
      @(posedge clk);
      #1 check("reset held", out, 32'h0);

      // Release, ADD 5+5: no change before the edge, 10 after it
      @(negedge clk);
      rst_n = 1'b1;
      opsel = 6'h00; A = 32'd5; B = 32'd5;
      #2 check("pre-edge", out, 32'h0);
      @(posedge clk);
      #1 check("ADD after rst", out, 32'd10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the bench never hangs
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
